// File: rtl/req_trans_segmenter_pkg.sv
// Shared constants for the requester transmit segmenter: field offsets, PMTU codes,
// PSN width and FSM state encoding.
package req_trans_segmenter_pkg;

  localparam int unsigned CxtHeadW  = 128;
  localparam int unsigned MetaW     = 256;
  localparam int unsigned NetMetaW  = 128;
  localparam int unsigned PsnUpdW   = 40;

  localparam int unsigned PsnW      = 24;
  localparam int unsigned QpnW      = 16;
  localparam int unsigned LenW      = 32;
  localparam int unsigned OpW       = 5;
  localparam int unsigned PmtuCodeW = 3;
  localparam int unsigned PayloadW  = 13;
  localparam int unsigned Log2W     = 4;

  // Context head fields
  localparam int unsigned HeadPsnOff  = 0;
  localparam int unsigned HeadPmtuOff = 24;
  localparam int unsigned HeadUsedW   = 27;

  // Sub-WQE meta fields
  localparam int unsigned DataQpnOff = 0;
  localparam int unsigned DataLenOff = 16;
  localparam int unsigned DataOpOff  = 48;
  localparam int unsigned DataUsedW  = 53;

  // Per-packet net meta fields
  localparam int unsigned NmQpnOff   = 0;
  localparam int unsigned NmPsnOff   = 16;
  localparam int unsigned NmPayOff   = 40;
  localparam int unsigned NmOpOff    = 53;
  localparam int unsigned NmFirstBit = 58;
  localparam int unsigned NmLastBit  = 59;
  localparam int unsigned NmOffOff   = 60;

  // PSN write-back fields
  localparam int unsigned PuQpnOff = 0;
  localparam int unsigned PuPsnOff = 16;

  localparam logic [PmtuCodeW-1:0] Pmtu256  = 3'd1;
  localparam logic [PmtuCodeW-1:0] Pmtu512  = 3'd2;
  localparam logic [PmtuCodeW-1:0] Pmtu1024 = 3'd3;
  localparam logic [PmtuCodeW-1:0] Pmtu2048 = 3'd4;
  localparam logic [PmtuCodeW-1:0] Pmtu4096 = 3'd5;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSeg    = 2'd1;
  localparam logic [1:0] StUpdate = 2'd2;

  function automatic logic [NetMetaW-1:0] pack_net_meta(
    input logic [QpnW-1:0]     qpn,
    input logic [PsnW-1:0]     psn,
    input logic [PayloadW-1:0] payload,
    input logic [OpW-1:0]      opcode,
    input logic                first,
    input logic                last,
    input logic [LenW-1:0]     offset
  );
    logic [NetMetaW-1:0] m;
    m = '0;
    m[NmQpnOff +: QpnW]     = qpn;
    m[NmPsnOff +: PsnW]     = psn;
    m[NmPayOff +: PayloadW] = payload;
    m[NmOpOff +: OpW]       = opcode;
    m[NmFirstBit]           = first;
    m[NmLastBit]            = last;
    m[NmOffOff +: LenW]     = offset;
    return m;
  endfunction

endpackage

// File: rtl/req_trans_segmenter_if.sv
// Bus bundle for the segmenter: context-fetch completion in, packet meta and PSN
// write-back out.
interface req_trans_segmenter_if #(
  parameter int unsigned CXT_HEAD_WIDTH = req_trans_segmenter_pkg::CxtHeadW,
  parameter int unsigned META_WIDTH     = req_trans_segmenter_pkg::MetaW,
  parameter int unsigned NET_META_WIDTH = req_trans_segmenter_pkg::NetMetaW
);

  logic                      fetch_cxt_egress_valid;
  logic [CXT_HEAD_WIDTH-1:0] fetch_cxt_egress_head;
  logic [META_WIDTH-1:0]     fetch_cxt_egress_data;
  logic                      fetch_cxt_egress_start;
  logic                      fetch_cxt_egress_last;
  logic                      fetch_cxt_egress_ready;

  logic                      net_meta_valid;
  logic [NET_META_WIDTH-1:0] net_meta_data;
  logic                      net_meta_ready;

  logic                      psn_update_valid;
  logic [39:0]               psn_update_data;
  logic                      psn_update_ready;

  // Upstream/downstream environment side
  modport master (
    output fetch_cxt_egress_valid, fetch_cxt_egress_head, fetch_cxt_egress_data,
    output fetch_cxt_egress_start, fetch_cxt_egress_last,
    input  fetch_cxt_egress_ready,
    input  net_meta_valid, net_meta_data,
    output net_meta_ready,
    input  psn_update_valid, psn_update_data,
    output psn_update_ready
  );

  // Segmenter side
  modport slave (
    input  fetch_cxt_egress_valid, fetch_cxt_egress_head, fetch_cxt_egress_data,
    input  fetch_cxt_egress_start, fetch_cxt_egress_last,
    output fetch_cxt_egress_ready,
    output net_meta_valid, net_meta_data,
    input  net_meta_ready,
    output psn_update_valid, psn_update_data,
    input  psn_update_ready
  );

endinterface

// File: rtl/req_trans_pmtu_decode.sv
// Maps the 3-bit PMTU code to payload bytes and log2; unknown codes fall back to 4096.
module req_trans_pmtu_decode
  import req_trans_segmenter_pkg::*;
(
  input  logic [PmtuCodeW-1:0] code,
  output logic [PayloadW-1:0]  num_bytes,
  output logic [Log2W-1:0]     log2_bytes
);

  always_comb begin
    case (code)
      Pmtu256:  log2_bytes = 4'd8;
      Pmtu512:  log2_bytes = 4'd9;
      Pmtu1024: log2_bytes = 4'd10;
      Pmtu2048: log2_bytes = 4'd11;
      Pmtu4096: log2_bytes = 4'd12;
      default:  log2_bytes = 4'd12;
    endcase
    num_bytes = PayloadW'(1) << log2_bytes;
  end

endmodule

// File: rtl/req_trans_segmenter.sv
// Splits one sub-WQE completion into PMTU-sized packet metadata with consecutive PSNs,
// then issues a next-PSN write-back.
module req_trans_segmenter
  import req_trans_segmenter_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  req_trans_segmenter_if.slave bus
);

  logic [1:0]          state_q, state_d;
  logic                alive_q;
  logic [QpnW-1:0]     qpn_q, qpn_d;
  logic [OpW-1:0]      opcode_q, opcode_d;
  logic [PsnW-1:0]     psn_q, psn_d;
  logic [PayloadW-1:0] pmtu_q, pmtu_d;
  logic [LenW-1:0]     offset_q, offset_d;
  logic [LenW-1:0]     remaining_q, remaining_d;

  logic [PayloadW-1:0] pmtu_bytes;
  logic [Log2W-1:0]    pmtu_log2;
  logic [PayloadW-1:0] payload;
  logic                is_first, is_last;
  logic                egress_ready, egress_fire;
  logic                meta_valid, meta_fire;
  logic                upd_valid, upd_fire;

  req_trans_pmtu_decode u_pmtu_decode (
    .code       (bus.fetch_cxt_egress_head[HeadPmtuOff +: PmtuCodeW]),
    .num_bytes  (pmtu_bytes),
    .log2_bytes (pmtu_log2)
  );

  // alive_q holds ready low for the reset cycle itself
  assign egress_ready = alive_q && (state_q == StIdle);
  assign meta_valid   = (state_q == StSeg);
  assign upd_valid    = (state_q == StUpdate);
  assign egress_fire  = egress_ready && bus.fetch_cxt_egress_valid;
  assign meta_fire    = meta_valid && bus.net_meta_ready;
  assign upd_fire     = upd_valid && bus.psn_update_ready;

  // remaining <= pmtu also covers the zero-length single packet
  assign is_last  = remaining_q <= LenW'(pmtu_q);
  assign is_first = (offset_q == '0);
  assign payload  = is_last ? remaining_q[PayloadW-1:0] : pmtu_q;

  always_comb begin
    state_d     = state_q;
    qpn_d       = qpn_q;
    opcode_d    = opcode_q;
    psn_d       = psn_q;
    pmtu_d      = pmtu_q;
    offset_d    = offset_q;
    remaining_d = remaining_q;
    case (state_q)
      StIdle: begin
        if (egress_fire) begin
          qpn_d       = bus.fetch_cxt_egress_data[DataQpnOff +: QpnW];
          opcode_d    = bus.fetch_cxt_egress_data[DataOpOff +: OpW];
          remaining_d = bus.fetch_cxt_egress_data[DataLenOff +: LenW];
          psn_d       = bus.fetch_cxt_egress_head[HeadPsnOff +: PsnW];
          pmtu_d      = pmtu_bytes;
          offset_d    = '0;
          state_d     = StSeg;
        end
      end
      StSeg: begin
        if (meta_fire) begin
          psn_d       = psn_q + PsnW'(1);
          offset_d    = offset_q + LenW'(payload);
          remaining_d = remaining_q - LenW'(payload);
          if (is_last) state_d = StUpdate;
        end
      end
      StUpdate: begin
        if (upd_fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      alive_q     <= 1'b0;
      qpn_q       <= '0;
      opcode_q    <= '0;
      psn_q       <= '0;
      pmtu_q      <= '0;
      offset_q    <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      alive_q     <= 1'b1;
      qpn_q       <= qpn_d;
      opcode_q    <= opcode_d;
      psn_q       <= psn_d;
      pmtu_q      <= pmtu_d;
      offset_q    <= offset_d;
      remaining_q <= remaining_d;
    end
  end

  assign bus.fetch_cxt_egress_ready = egress_ready;
  assign bus.net_meta_valid         = meta_valid;
  assign bus.net_meta_data          = meta_valid ?
      pack_net_meta(qpn_q, psn_q, payload, opcode_q, is_first, is_last, offset_q) : '0;
  assign bus.psn_update_valid       = upd_valid;
  assign bus.psn_update_data        = upd_valid ? {psn_q, qpn_q} : '0;

  logic unused_in;
  assign unused_in = ^{bus.fetch_cxt_egress_head[CxtHeadW-1:HeadUsedW],
                       bus.fetch_cxt_egress_data[MetaW-1:DataUsedW],
                       bus.fetch_cxt_egress_start, bus.fetch_cxt_egress_last, pmtu_log2};

endmodule
